power_spectrum: RTL and testbench
=================================

POWER_SPECTRUM -- requirements
Module: power_spectrum

Interface
REQ-001 The block SHALL have parameter FFT_SIZE, default 512, meaning FFT length N per frame (power of two, >= 4).
REQ-002 The block SHALL have parameter BIN_W, default $clog2(FFT_SIZE/2+1), meaning the width of the output bin index.
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all logic rises on posedge clk.
REQ-004 The block SHALL have port rst  input  1  meaning reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid  input  1  meaning an FFT bin is presented.
REQ-006 The block SHALL have port in_ready  output  1  meaning the block accepts the bin this cycle.
REQ-007 The block SHALL have port in_data  input  64  meaning complex_pkg::complex; re is [63:32] and im is [31:0], both signed Q1.31.
REQ-008 The block SHALL have port in_last  input  1  meaning the upstream FFT marks bin N-1 of a frame.
REQ-009 The block SHALL have port out_valid  output  1  meaning a power value is presented.
REQ-010 The block SHALL have port out_ready  input  1  meaning the downstream (mel filterbank) accepts it.
REQ-011 The block SHALL have port out_power  output  64  meaning unsigned |X|^2 = re*re + im*im.
REQ-012 The block SHALL have port out_bin  output  BIN_W  meaning the bin index 0..N/2 of out_power.
REQ-013 The block SHALL have port out_last  output  1  meaning high with bin N/2, the last forwarded bin of a frame.
REQ-014 The block SHALL have port frame_err  output  1  meaning a sticky flag for a framing mismatch.

Function
REQ-015 Handshakes SHALL be valid/ready; a transfer occurs only on a cycle with valid && ready; out_valid, once high, SHALL hold it and keep out_power/out_bin/out_last stable until out_ready.
REQ-016 The datapath SHALL be a 2-stage pipeline: S1 registers re*re and im*im as 64-bit signed products; S2 (output register) registers their sum as 64-bit unsigned.
REQ-017 Latency from an input handshake to out_valid SHALL be 2 cycles with no stall.
REQ-018 The stage enables SHALL be: en2 = !v2 || out_ready, en1 = !v1 || en2, in_ready = en1 && !rst; throughput SHALL be 1 bin/cycle with out_ready held high.
REQ-019 A bin counter SHALL increment on each input handshake and wrap from N-1 to 0; the bin counter value SHALL travel with the data through S1/S2.
REQ-020 Bins 0..N/2 SHALL enter S1 with v1=1; bins N/2+1..N-1 SHALL be accepted (same in_ready rule) but SHALL load v1=0 and produce no output.
REQ-021 out_last SHALL be 1 exactly when out_bin == N/2.
REQ-022 Sum arithmetic: the maximum input (-2^31,-2^31) SHALL yield 2^63 without wrap; no rounding or shifting SHALL be applied.
REQ-023 If in_last is accepted while the counter != N-1, frame_err SHALL set and the counter SHALL be forced to 0 for the next beat (resync); data of that beat SHALL be treated per REQ-020 using its pre-resync index.
REQ-024 If the counter == N-1 is accepted without in_last, frame_err SHALL set; the counter SHALL still wrap to 0.
REQ-025 frame_err SHALL be sticky until rst.
REQ-026 A bubble in in_valid SHALL NOT advance the counter or create output.

Reset
REQ-027 While rst is high, in_ready SHALL be 0 and the block SHALL clear v1, v2, the bin counter and frame_err; out_valid=0, out_power=0, out_bin=0, out_last=0 on the cycle after rst.
REQ-028 rst mid-frame SHALL discard all in-flight bins; the first beat accepted after rst SHALL be bin 0.

Verification
REQ-029 N=8, in_data re=3 im=4, in_valid and out_ready held high -> out_power=25, out_bin=0, out_valid exactly 2 cycles after the handshake.
REQ-030 re=im=0x8000_0000 -> out_power=0x8000_0000_0000_0000; re=0x7FFF_FFFF, im=0 -> 0x3FFF_FFFF_0000_0001.
REQ-031 N=8, 8 back-to-back bins with in_last on bin 7 -> 5 outputs with bins 0..4, out_last only on bin 4, no output for bins 5..7, frame_err=0.
REQ-032 Stream continuously, drop out_ready for 3 cycles -> in_ready falls after 2 further accepts, out_* held stable, no bin lost or duplicated after release.
REQ-033 N=8, in_last on bin 3 -> frame_err=1, next accepted beat is output as bin 0; frame_err stays 1 through the following good frame.
REQ-034 Assert rst for 1 cycle after bin 2 with 2 bins in flight -> no output for those bins, out_valid=0, next beat is out_bin 0.

Source files
------------

// File: rtl/power_spectrum.sv
// Power spectrum stage: turns a stream of complex FFT bins into |X|^2 for bins 0..N/2,
// through a two-stage elastic pipeline with frame tracking and a sticky framing-error flag.
module power_spectrum #(
  parameter int FFT_SIZE = 512,
  parameter int BIN_W    = $clog2(FFT_SIZE/2+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_power,
  output logic [BIN_W-1:0] out_bin,
  output logic             out_last,
  output logic             frame_err
);

  localparam int CW = $clog2(FFT_SIZE);
  localparam logic [CW-1:0]    LastIdx = CW'(FFT_SIZE - 1);
  localparam logic [CW-1:0]    HalfIdx = CW'(FFT_SIZE / 2);
  localparam logic [BIN_W-1:0] HalfBin = BIN_W'(FFT_SIZE / 2);

  logic                    en1, en2, accept;
  logic                    v1_q, v2_q;
  logic signed [63:0]      re2_q, im2_q;
  logic signed [63:0]      reExt, imExt;
  logic [BIN_W-1:0]        bin1_q, bin2_q;
  logic [63:0]             power_q;
  logic                    last2_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    err_q, err_d;

  assign en2      = !v2_q || out_ready;
  assign en1      = !v1_q || en2;
  assign in_ready = en1 && !rst;
  assign accept   = in_valid && in_ready;

  // Sign-extend so the squares come out of a plain 64-bit multiply without any width games.
  assign reExt = {{32{in_data[63]}}, in_data[63:32]};
  assign imExt = {{32{in_data[31]}}, in_data[31:0]};

  // A stray in_last resyncs the frame to bin 0; a missing one still wraps, but both are errors.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (accept) begin
      if (in_last && (cnt_q != LastIdx)) begin
        err_d = 1'b1;
        cnt_d = '0;
      end else if (cnt_q == LastIdx) begin
        if (!in_last) err_d = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Upper-half bins are still consumed but enter S1 as bubbles, since they mirror the lower half.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      re2_q  <= '0;
      im2_q  <= '0;
      bin1_q <= '0;
    end else if (en1) begin
      v1_q <= accept && (cnt_q <= HalfIdx);
      if (accept) begin
        re2_q  <= reExt * reExt;
        im2_q  <= imExt * imExt;
        bin1_q <= BIN_W'(cnt_q);
      end
    end
  end

  // Both squares are non-negative, so an unsigned add reaches 2^63 without wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q    <= 1'b0;
      power_q <= '0;
      bin2_q  <= '0;
      last2_q <= 1'b0;
    end else if (en2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        power_q <= $unsigned(re2_q) + $unsigned(im2_q);
        bin2_q  <= bin1_q;
        last2_q <= (bin1_q == HalfBin);
      end
    end
  end

  assign out_valid = v2_q;
  assign out_power = power_q;
  assign out_bin   = bin2_q;
  assign out_last  = last2_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_power_spectrum.sv
// Directed bench for power_spectrum at N=8: a queue-based frame model checked every cycle,
// plus hand-computed expectations for latency, extreme values, stalls, resets and framing errors.
module tb_power_spectrum;
  localparam int N  = 8;
  localparam int BW = $clog2(N/2+1);

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, in_last;
  logic          out_valid, out_ready, out_last, frame_err;
  logic [63:0]   in_data, out_power;
  logic [BW-1:0] out_bin;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [63:0]   power;
    logic [BW-1:0] bin;
    logic          last;
  } expT;

  expT  expQ[$];
  int   modelIdx, outCount, lastCount, c0, l0, stallAccepts;
  logic errModel, prevStall;

  always #5 clk = ~clk;

  power_spectrum #(.FFT_SIZE(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_power(out_power),
    .out_bin(out_bin), .out_last(out_last), .frame_err(frame_err)
  );

  function automatic logic [63:0] powerOf(input logic [31:0] re, input logic [31:0] im);
    longint r, i;
    r = longint'($signed(re));
    i = longint'($signed(im));
    return 64'(r * r + i * i);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Model: every accepted beat in the lower half of a frame must come out, in order, exactly once.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("in_ready_in_rst", 64'(in_ready), 64'h0);
      expQ.delete();
      modelIdx  = 0;
      errModel  = 1'b0;
      prevStall = 1'b0;
    end else begin
      checkOutput("frame_err", 64'(frame_err), 64'(errModel));
      if (prevStall) checkOutput("hold_valid", 64'(out_valid), 64'h1);
      if (out_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("spurious_out_valid", 64'(out_valid), 64'h0);
        end else begin
          checkOutput("out_power", out_power, expQ[0].power);
          checkOutput("out_bin", 64'(out_bin), 64'(expQ[0].bin));
          checkOutput("out_last", 64'(out_last), 64'(expQ[0].last));
          if (out_ready) begin
            void'(expQ.pop_front());
            outCount++;
            if (out_last) lastCount++;
          end
        end
      end
      prevStall = out_valid && !out_ready;
      if (in_valid && in_ready) begin
        if (modelIdx <= N/2)
          expQ.push_back('{powerOf(in_data[63:32], in_data[31:0]), BW'(modelIdx), (modelIdx == N/2)});
        if (in_last && modelIdx != N-1) begin
          errModel = 1'b1;
          modelIdx = 0;
        end else if (modelIdx == N-1) begin
          if (!in_last) errModel = 1'b1;
          modelIdx = 0;
        end else begin
          modelIdx++;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] re, input logic [31:0] im, input logic last);
    logic accepted;
    int   waitCycles;
    in_valid   = 1'b1;
    in_data    = {re, im};
    in_last    = last;
    accepted   = 1'b0;
    waitCycles = 0;
    while (!accepted && waitCycles < 50) begin
      @(negedge clk);
      accepted = in_ready;
      @(posedge clk);
      #1;
      waitCycles++;
    end
    checkOutput("accept", 64'(accepted), 64'h1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic applyFrame(input int first, input int lastIdx, input int lastMark);
    for (int b = first; b <= lastIdx; b++)
      applyStimulus(32'(b * 1000 + 7), 32'(-3 * b), (b == lastMark));
  endtask

  task automatic awaitOutput(input string name, input logic [63:0] expPower, input int expBin);
    logic seen;
    int   waitCycles;
    seen       = 1'b0;
    waitCycles = 0;
    while (!seen && waitCycles < 20) begin
      @(negedge clk);
      seen = out_valid;
      waitCycles++;
    end
    checkOutput({name, "_valid"}, 64'(seen), 64'h1);
    if (seen) begin
      checkOutput({name, "_power"}, out_power, expPower);
      checkOutput({name, "_bin"}, 64'(out_bin), 64'(expBin));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    outCount = 0; lastCount = 0; modelIdx = 0; errModel = 1'b0; prevStall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'h0);
    checkOutput("rst_out_power", out_power, 64'h0);
    checkOutput("rst_out_bin", 64'(out_bin), 64'h0);
    checkOutput("rst_out_last", 64'(out_last), 64'h0);
    checkOutput("rst_frame_err", 64'(frame_err), 64'h0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'h0);
    rst = 1'b0;

    // 3^2 + 4^2, output visible two cycles after the handshake cycle
    applyStimulus(32'd3, 32'd4, 1'b0);
    checkOutput("lat1_out_valid", 64'(out_valid), 64'h0);
    @(posedge clk);
    #1;
    checkOutput("lat2_out_valid", 64'(out_valid), 64'h1);
    checkOutput("lat2_out_power", out_power, 64'd25);
    checkOutput("lat2_out_bin", 64'(out_bin), 64'h0);
    applyFrame(1, 7, 7);
    settle();

    c0 = outCount; l0 = lastCount;
    applyFrame(0, 7, 7);
    settle();
    checkOutput("frame_out_count", 64'(outCount - c0), 64'd5);
    checkOutput("frame_last_count", 64'(lastCount - l0), 64'd1);
    checkOutput("frame_err_clean", 64'(frame_err), 64'h0);

    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0);
    awaitOutput("max_neg", 64'h8000_0000_0000_0000, 0);
    applyStimulus(32'h7FFF_FFFF, 32'h0, 1'b0);
    awaitOutput("max_pos", 64'h3FFF_FFFF_0000_0001, 1);
    applyFrame(2, 7, 7);
    settle();

    c0 = outCount;
    fork
      begin
        applyFrame(0, 7, 7);
        applyFrame(0, 7, 7);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        stallAccepts = 0;
        repeat (3) begin
          @(negedge clk);
          if (in_valid && in_ready) stallAccepts++;
        end
        checkOutput("stall_in_ready", 64'(in_ready), 64'h0);
        checkOutput("stall_accepts_le2", 64'(stallAccepts <= 2), 64'h1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    settle();
    checkOutput("stall_out_count", 64'(outCount - c0), 64'd10);
    checkOutput("stall_frame_err", 64'(frame_err), 64'h0);

    applyFrame(0, 2, -1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("post_rst_out_valid", 64'(out_valid), 64'h0);
    applyStimulus(32'd3, 32'd4, 1'b0);
    awaitOutput("after_rst", 64'd25, 0);

    applyFrame(1, 3, 3);
    settle();
    checkOutput("err_set", 64'(frame_err), 64'h1);
    applyStimulus(32'd6, 32'd8, 1'b0);
    awaitOutput("resync", 64'd100, 0);
    applyFrame(1, 7, 7);
    settle();
    checkOutput("err_sticky", 64'(frame_err), 64'h1);

    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("err_cleared", 64'(frame_err), 64'h0);
    applyFrame(0, 7, -1);
    settle();
    checkOutput("err_no_last", 64'(frame_err), 64'h1);
    applyStimulus(32'd0, 32'h10, 1'b0);
    awaitOutput("wrap_no_last", 64'd256, 0);
    settle();
    checkOutput("queue_drained", 64'(expQ.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
